// File: rtl/if_id_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_skid_stage
//  Description : IF/ID pipeline stage carrying {PC+4, instruction} from fetch
//                to decode over a valid/ready handshake, backed by a 2-entry
//                skid buffer (MAIN drives the outputs, SKID absorbs the one
//                instruction fetch can still push after decode stalls).
//                A flush squashes every held entry into a NOP bubble and the
//                squashed valid entries are counted in a saturating counter.
//  Ports       : clk, reset      - rising-edge clock, async active-high reset
//                in_valid/in_ready/in_pc/in_instr     - fetch side
//                out_valid/out_ready/out_pc/out_instr - decode side
//                flush           - synchronous squash of all held entries
//                occupancy       - number of entries held (0..2)
//                squash_cnt      - saturating count of squashed entries
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_stage #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   squash_cnt
);

    logic               r_main_valid;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;
    logic               r_skid_valid;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [CNT_W-1:0]   r_squash_cnt;

    logic               w_accept;
    logic               w_consume;
    logic [1:0]         w_squash_add;
    logic [CNT_W:0]     w_squash_sum;
    logic [CNT_W-1:0]   w_squash_next;

    // SKID is only ever filled while MAIN is full, so "SKID empty" is exactly
    // "room for one more". Driving in_ready straight from the SKID valid flop
    // keeps out_ready off the fetch-side timing path.
    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;

    // An entry consumed on the flush edge has been delivered; only what would
    // remain after that transfer is counted as squashed. w_consume implies
    // r_main_valid, so the subtraction never underflows.
    assign w_squash_add  = {1'b0, r_main_valid} + {1'b0, r_skid_valid} - {1'b0, w_consume};
    assign w_squash_sum  = {1'b0, r_squash_cnt} + (CNT_W+1)'(w_squash_add);
    assign w_squash_next = w_squash_sum[CNT_W] ? {CNT_W{1'b1}} : w_squash_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_instr <= NOP_INSTR;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_squash_cnt <= '0;
        end else if (flush) begin
            // Incoming instruction is dropped too: fetch restarts at the new PC.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_squash_cnt <= w_squash_next;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                // Older SKID entry advances first; in_ready is low so no accept.
                r_main_valid <= 1'b1;
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_pc    <= in_pc;
                r_main_instr <= in_instr;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Decode stalled with MAIN full: park the late arrival in SKID.
            r_skid_valid <= 1'b1;
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
        end
    end

    // Empty MAIN is presented as a clean bubble regardless of stale contents.
    assign out_valid  = r_main_valid;
    assign out_pc     = r_main_valid ? r_main_pc    : '0;
    assign out_instr  = r_main_valid ? r_main_instr : NOP_INSTR;
    assign occupancy  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign squash_cnt = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_skid_stage
//  Description : Self-checking bench for if_id_skid_stage. Two instances share
//                all inputs: one with the default 16-bit squash counter and
//                one with a 2-bit counter to exercise saturation. A queue-based
//                reference model predicts held entries and counters; a monitor
//                compares the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_stage;

    localparam int unsigned c_PC_W    = 32;
    localparam int unsigned c_INSTR_W = 32;
    localparam int unsigned c_CNT_W   = 16;
    localparam int unsigned c_CNT_W_B = 2;
    localparam int          c_SAT_A   = 65535;
    localparam int          c_SAT_B   = 3;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic [c_PC_W-1:0]    in_pc;
    logic [c_INSTR_W-1:0] in_instr;
    logic                 out_ready;
    logic                 flush;

    logic                 in_ready,  in_ready_b;
    logic                 out_valid, out_valid_b;
    logic [c_PC_W-1:0]    out_pc,    out_pc_b;
    logic [c_INSTR_W-1:0] out_instr, out_instr_b;
    logic [1:0]           occupancy, occupancy_b;
    logic [c_CNT_W-1:0]   squash_cnt;
    logic [c_CNT_W_B-1:0] squash_cnt_b;

    int errors = 0;
    int checks = 0;

    if_id_skid_stage #(
        .PC_W(c_PC_W), .INSTR_W(c_INSTR_W), .NOP_INSTR('0), .CNT_W(c_CNT_W)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .flush(flush), .occupancy(occupancy), .squash_cnt(squash_cnt)
    );

    if_id_skid_stage #(
        .PC_W(c_PC_W), .INSTR_W(c_INSTR_W), .NOP_INSTR('0), .CNT_W(c_CNT_W_B)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_instr(out_instr_b),
        .flush(flush), .occupancy(occupancy_b), .squash_cnt(squash_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: the stage is a FIFO of at most two entries.
    // exp_q holds {pc, instr} of every entry currently in the stage,
    // oldest first; the head is what decode must see.
    // ------------------------------------------------------------------
    logic [63:0] exp_q[$];
    int          m_sq_a = 0;
    int          m_sq_b = 0;

    always @(posedge clk or posedge reset) begin : model
        int held;
        bit cons;
        bit acc;
        if (reset) begin
            exp_q.delete();
            m_sq_a = 0;
            m_sq_b = 0;
        end else begin
            held = exp_q.size();
            cons = (held > 0) && out_ready;
            acc  = in_valid && (held < 2);
            if (flush) begin
                m_sq_a = sat(m_sq_a + held - int'(cons), c_SAT_A);
                m_sq_b = sat(m_sq_b + held - int'(cons), c_SAT_B);
                exp_q.delete();
            end else begin
                if (cons) void'(exp_q.pop_front());
                if (acc)  exp_q.push_back({in_pc, in_instr});
            end
        end
    end

    // Monitor: compares both instances against the model between edges.
    always @(negedge clk) begin : monitor
        logic [63:0] head;
        int          n;
        n = exp_q.size();
        chk("out_valid", {63'd0, out_valid}, {63'd0, n > 0});
        chk("in_ready",  {63'd0, in_ready},  {63'd0, n < 2});
        chk("occupancy", {62'd0, occupancy}, 64'(n));
        if (n > 0) begin
            head = exp_q[0];
            chk("out_pc",    {32'd0, out_pc},    {32'd0, head[63:32]});
            chk("out_instr", {32'd0, out_instr}, {32'd0, head[31:0]});
        end else begin
            chk("bubble_pc",    {32'd0, out_pc},    64'd0);
            chk("bubble_instr", {32'd0, out_instr}, 64'd0);
        end
        chk("squash_cnt",   {48'd0, squash_cnt},   64'(m_sq_a));
        chk("squash_cnt_b", {62'd0, squash_cnt_b}, 64'(m_sq_b));
        chk("b_occupancy",  {62'd0, occupancy_b},  {62'd0, occupancy});
        chk("b_out_instr",  {32'd0, out_instr_b},  {32'd0, out_instr});
    end

    // One cycle of stimulus: apply just after an edge, sample at the next.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_two(input logic [31:0] base);
        drive(1'b1, base + 32'd4, 32'hA0A0_0000 | base, 1'b0, 1'b0);
        drive(1'b1, base + 32'd8, 32'hB0B0_0000 | base, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] c_A = 32'hAAAA_0001;
    localparam logic [31:0] c_B = 32'hBBBB_0002;
    localparam logic [31:0] c_C = 32'hCCCC_0003;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;

        // Streaming: one instruction per cycle, single entry held.
        drive(1'b1, 32'd4,  c_A, 1'b1, 1'b0);
        chk("t2_a", {32'd0, out_instr}, {32'd0, c_A});
        chk("t2_occ_a", {62'd0, occupancy}, 64'd1);
        drive(1'b1, 32'd8,  c_B, 1'b1, 1'b0);
        chk("t2_b", {32'd0, out_instr}, {32'd0, c_B});
        chk("t2_occ_b", {62'd0, occupancy}, 64'd1);
        drive(1'b1, 32'd12, c_C, 1'b1, 1'b0);
        chk("t2_c", {32'd0, out_instr}, {32'd0, c_C});
        chk("t2_occ_c", {62'd0, occupancy}, 64'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("t2_drain", {63'd0, out_valid}, 64'd0);

        // Stall into the skid buffer, then release.
        drive(1'b1, 32'd4, c_A, 1'b0, 1'b0);
        drive(1'b1, 32'd8, c_B, 1'b0, 1'b0);
        chk("t3_occ2",   {62'd0, occupancy}, 64'd2);
        chk("t3_notrdy", {63'd0, in_ready},  64'd0);
        chk("t3_hold_a", {32'd0, out_instr}, {32'd0, c_A});
        drive(1'b1, 32'd12, c_C, 1'b0, 1'b0);
        chk("t3_still_a", {32'd0, out_instr}, {32'd0, c_A});
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("t3_b",    {32'd0, out_instr}, {32'd0, c_B});
        chk("t3_rdy1", {63'd0, in_ready},  64'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("t3_empty", {62'd0, occupancy}, 64'd0);

        // Flush with both entries held and a new instruction offered.
        fill_two(32'h100);
        drive(1'b1, 32'd16, 32'hDEAD_0016, 1'b0, 1'b1);
        chk("t4_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_nop",   {32'd0, out_instr}, 64'd0);
        chk("t4_occ",   {62'd0, occupancy}, 64'd0);
        chk("t4_sq",    {48'd0, squash_cnt}, 64'd2);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush on the same edge MAIN is consumed.
        fill_two(32'h200);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("t5_sq",  {48'd0, squash_cnt}, 64'd3);
        chk("t5_occ", {62'd0, occupancy},  64'd0);

        // Asynchronous reset mid-stream with both entries held.
        fill_two(32'h300);
        #2 reset = 1'b1;
        #1;
        chk("t1_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_instr", {32'd0, out_instr}, 64'd0);
        chk("t1_rdy",   {63'd0, in_ready},  64'd1);
        chk("t1_sq",    {48'd0, squash_cnt}, 64'd0);
        chk("t1_occ",   {62'd0, occupancy}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Saturation of the 2-bit counter.
        for (int k = 0; k < 3; k++) begin
            fill_two(32'h400 + 32'(k * 16));
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("t6_sq_b", {62'd0, squash_cnt_b}, (k == 0) ? 64'd2 : 64'd3);
            chk("t6_sq_a", {48'd0, squash_cnt},   64'(2 * (k + 1)));
        end

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, $urandom, $urandom,
                  ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
